// File: rtl/gcd_job_arbiter.sv
// Round-robin front end sharing one GCD engine among NREQ requesters.
// Optional watchdog enabled by defining GCD_ARB_TIMEOUT_EN (adds parameter TMO).
module gcd_job_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = $clog2(NREQ)
`ifdef GCD_ARB_TIMEOUT_EN
  ,
  parameter int TMO  = 1023
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic              eng_go,
  output logic [W-1:0]      eng_a,
  output logic [W-1:0]      eng_b,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic [W-1:0]      eng_result
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            resp_valid_q, resp_valid_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic [W-1:0]    resp_data_q, resp_data_d;
  logic            resp_err_q, resp_err_d;
  logic            busy_q, busy_d;
  logic            eng_go_q, eng_go_d;
  logic [W-1:0]    eng_a_q, eng_a_d;
  logic [W-1:0]    eng_b_q, eng_b_d;
  logic            eng_abort_q, eng_abort_d;

  logic            found;
  logic [IDW-1:0]  win;
  logic [IDW:0]    sum;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];
  logic            timeout;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*W +: W];
      b_arr[i] = req_b[i*W +: W];
    end
  end

  // Search starts just after the last winner and wraps modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    sum   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!found && req[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == LAUNCH)    cnt_d = '0;
    else if (state_q == WAIT) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A done pulse in the expiry cycle still wins over the abort.
  assign timeout = (state_q == WAIT) && (cnt_q == CW'(TMO - 1)) && !eng_done;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = '0;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = 1'b0;
    eng_go_d     = 1'b0;
    eng_a_d      = eng_a_q;
    eng_b_d      = eng_b_q;
    eng_abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d     = win;
          gnt_d     = NREQ'(1) << win;
          eng_a_d   = a_arr[win];
          eng_b_d   = b_arr[win];
          resp_id_d = win;
          // gcd(x,0) = x, so zero-operand jobs never touch the engine.
          if ((a_arr[win] == '0) || (b_arr[win] == '0)) begin
            resp_data_d  = a_arr[win] | b_arr[win];
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            eng_go_d = 1'b1;
            state_d  = LAUNCH;
          end
        end
      end
      LAUNCH: state_d = WAIT;
      WAIT: begin
        if (eng_done) begin
          resp_data_d  = eng_result;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (timeout) begin
          resp_data_d  = '0;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          eng_abort_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(NREQ - 1);
      gnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      eng_go_q     <= 1'b0;
      eng_a_q      <= '0;
      eng_b_q      <= '0;
      eng_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      eng_go_q     <= eng_go_d;
      eng_a_q      <= eng_a_d;
      eng_b_q      <= eng_b_d;
      eng_abort_q  <= eng_abort_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  assign eng_go     = eng_go_q;
  assign eng_a      = eng_a_q;
  assign eng_b      = eng_b_q;
  assign eng_abort  = eng_abort_q;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Self-checking bench for gcd_job_arbiter with a behavioural engine and a
// transaction-level round-robin/GCD reference model.
module tb_gcd_job_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;
  localparam int TMO  = 1023;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   gnt;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_data;
  logic              resp_err;
  logic              busy;
  logic              eng_go;
  logic [W-1:0]      eng_a;
  logic [W-1:0]      eng_b;
  logic              eng_abort;
  logic              eng_done;
  logic [W-1:0]      eng_result;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int done_cyc   = -10;
  int model_ptr  = NREQ - 1;
  bit engine_en  = 1'b1;
  int spur_req   = 0;

  gcd_job_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy), .eng_go(eng_go), .eng_a(eng_a), .eng_b(eng_b),
    .eng_abort(eng_abort), .eng_done(eng_done), .eng_result(eng_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  function automatic int rr_pick(input int p, input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return p;
  endfunction

  // Behavioural engine: answers each eng_go after a random latency.
  initial begin
    int lat;
    int spur_ack;
    logic [W-1:0] ga, gb;
    spur_ack   = 0;
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(posedge clk); #1;
      if (eng_go === 1'b1 && engine_en) begin
        ga  = eng_a;
        gb  = eng_b;
        lat = $urandom_range(1, 6);
        repeat (lat) begin @(posedge clk); #1; end
        if (engine_en) begin
          eng_done   = 1'b1;
          eng_result = gcd_ref(ga, gb);
          done_cyc   = cyc;
          @(posedge clk); #1;
          eng_done   = 1'b0;
        end
      end else if (spur_req != spur_ack) begin
        spur_ack   = spur_req;
        eng_done   = 1'b1;
        eng_result = W'($urandom);
        @(posedge clk); #1;
        eng_done   = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    @(negedge clk);
  endtask

  // Issues one arbitration round from an IDLE-cycle negedge and follows the
  // winning job to its response; returns at the next IDLE-cycle negedge.
  task automatic issue(input logic [NREQ-1:0] mask, input logic [NREQ*W-1:0] pa,
                       input logic [NREQ*W-1:0] pb, input bit keep);
    int w;
    logic [W-1:0] ea, eb, ex;
    logic [NREQ-1:0] eg;
    bit zero, seen;
    req = mask; req_a = pa; req_b = pb;
    w = rr_pick(model_ptr, mask);
    model_ptr = w;
    ea = pa[w*W +: W];
    eb = pb[w*W +: W];
    ex = gcd_ref(ea, eb);
    zero = (ea == 0) || (eb == 0);
    eg = '0; eg[w] = 1'b1;
    @(negedge clk);
    vectors++;
    if (gnt !== eg) begin miscompares++; $display("[TB] FAIL gnt: got %b want %b", gnt, eg); end
    vectors++;
    if (eng_go !== !zero) begin miscompares++; $display("[TB] FAIL eng_go: got %b want %b", eng_go, !zero); end
    vectors++;
    if (resp_valid !== zero) begin miscompares++; $display("[TB] FAIL early_resp: got %b want %b", resp_valid, zero); end
    if (zero) begin
      vectors++;
      if (resp_id !== IDW'(w)) begin miscompares++; $display("[TB] FAIL zero_id: got %0d want %0d", resp_id, w); end
      vectors++;
      if (resp_data !== ex) begin miscompares++; $display("[TB] FAIL zero_data: got %0d want %0d", resp_data, ex); end
    end else begin
      vectors++;
      if (eng_a !== ea || eng_b !== eb) begin
        miscompares++; $display("[TB] FAIL eng_ops: got %0d,%0d want %0d,%0d", eng_a, eng_b, ea, eb);
      end
    end
    if (!keep) req[w] = 1'b0;
    if (!zero) begin
      seen = 1'b0;
      for (int b = 0; b < 64 && !seen; b++) begin
        @(negedge clk);
        if (resp_valid === 1'b1) begin
          seen = 1'b1;
          vectors++;
          if (cyc !== done_cyc + 1) begin miscompares++; $display("[TB] FAIL resp_latency: got cycle %0d want %0d", cyc, done_cyc + 1); end
          vectors++;
          if (resp_id !== IDW'(w)) begin miscompares++; $display("[TB] FAIL resp_id: got %0d want %0d", resp_id, w); end
          vectors++;
          if (resp_data !== ex) begin miscompares++; $display("[TB] FAIL resp_data: got %0d want %0d (a=%0d b=%0d)", resp_data, ex, ea, eb); end
        end
      end
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL resp_wait: got no resp_valid want one within 64 cycles"); end
    end
    vectors++;
    if (resp_err !== 1'b0 && resp_valid === 1'b1) begin miscompares++; $display("[TB] FAIL resp_err: got %b want 0", resp_err); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL idle_after: got busy=%b valid=%b want 0,0", busy, resp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({gnt, resp_valid, resp_id, resp_data, resp_err, busy, eng_go, eng_a, eng_b, eng_abort} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got gnt=%b v=%b id=%0d d=%0d e=%b busy=%b go=%b a=%0d b=%0d ab=%b want all 0",
               gnt, resp_valid, resp_id, resp_data, resp_err, busy, eng_go, eng_a, eng_b, eng_abort);
    end
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || gnt !== '0) begin miscompares++; $display("[TB] FAIL post_reset_idle: got busy=%b gnt=%b want 0", busy, gnt); end
  endtask

  task automatic test_basic();
    issue(4'b0001, {16'd0, 16'd0, 16'd0, 16'd48}, {16'd0, 16'd0, 16'd0, 16'd18}, 1'b0);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int j = 0; j < 5; j++)
      issue(4'b1111, {16'd91, 16'd60, 16'd84, 16'd36}, {16'd65, 16'd48, 16'd18, 16'd24}, 1'b1);
    req = '0;
  endtask

  task automatic test_zero_operand();
    issue(4'b0100, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd0, 16'd35, 16'd0, 16'd0}, 1'b0);
    issue(4'b0100, {16'd0, 16'd0, 16'd0, 16'd0}, {16'd0, 16'd0, 16'd0, 16'd0}, 1'b0);
    issue(4'b0001, {16'd0, 16'd0, 16'd0, 16'd77}, {16'd0, 16'd0, 16'd0, 16'd0}, 1'b0);
  endtask

  task automatic test_random();
    logic [NREQ*W-1:0] pa, pb;
    logic [NREQ-1:0] mask;
    int g;
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        g = $urandom_range(1, 40);
        pa[i*W +: W] = W'(g * $urandom_range(1, 1500));
        pb[i*W +: W] = W'(g * $urandom_range(1, 1500));
        if ($urandom_range(0, 7) == 0) pa[i*W +: W] = '0;
        if ($urandom_range(0, 7) == 0) pb[i*W +: W] = '0;
      end
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      issue(mask, pa, pb, bit'($urandom_range(0, 1)));
    end
    req = '0;
  endtask

  task automatic test_spurious_done();
    spur_req++;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("[TB] FAIL spurious_done: got valid=%b busy=%b want 0,0", resp_valid, busy);
      end
    end
    issue(4'b1000, {16'd17, 16'd0, 16'd0, 16'd0}, {16'd5, 16'd0, 16'd0, 16'd0}, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    int bad;
    engine_en = 1'b0;
    req = 4'b0100; req_a = {16'd0, 16'd21, 16'd0, 16'd0}; req_b = {16'd0, 16'd14, 16'd0, 16'd0};
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt, resp_valid, resp_id, resp_data, resp_err, busy, eng_go, eng_a, eng_b, eng_abort} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got busy=%b a=%0d b=%0d id=%0d want all 0", busy, eng_a, eng_b, resp_id);
    end
    bad = 0;
    repeat (3) begin @(negedge clk); if (resp_valid !== 1'b0) bad++; end
    rst_n = 1'b1;
    model_ptr = NREQ - 1;
    engine_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (bad != 0 || resp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_resp: got %0d responses want 0", bad); end
    issue(4'b0010, {16'd0, 16'd0, 16'd21, 16'd0}, {16'd0, 16'd0, 16'd14, 16'd0}, 1'b0);
  endtask

  task automatic test_timeout();
    int go_cyc;
    int bad;
    bit seen;
    engine_en = 1'b0;
    req = 4'b0010; req_a = {16'd0, 16'd0, 16'd9, 16'd0}; req_b = {16'd0, 16'd0, 16'd6, 16'd0};
    model_ptr = rr_pick(model_ptr, 4'b0010);
    @(negedge clk);
    vectors++;
    if (gnt !== 4'b0010 || eng_go !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_launch: got gnt=%b go=%b want 0010,1", gnt, eng_go); end
    go_cyc = cyc;
    req = '0;
    bad = 0;
    seen = 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
    for (int k = 0; k < 1100 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        seen = 1'b1;
        vectors++;
        if (cyc !== go_cyc + TMO + 1) begin miscompares++; $display("[TB] FAIL tmo_latency: got cycle %0d want %0d", cyc, go_cyc + TMO + 1); end
        vectors++;
        if (eng_abort !== 1'b1 || resp_err !== 1'b1 || resp_data !== '0 || resp_id !== 2'd1) begin
          miscompares++; $display("[TB] FAIL tmo_resp: got abort=%b err=%b data=%0d id=%0d want 1,1,0,1", eng_abort, resp_err, resp_data, resp_id);
        end
      end else if (eng_abort !== 1'b0) bad++;
    end
    vectors++;
    if (!seen || bad != 0) begin miscompares++; $display("[TB] FAIL tmo_wait: got seen=%b early_aborts=%0d want 1,0", seen, bad); end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_idle: got busy=%b want 0", busy); end
`else
    repeat (1100) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b1 || eng_abort !== 1'b0 || resp_err !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("[TB] FAIL no_timeout_hold: got %0d bad cycles want 0", bad); end
    do_reset();
`endif
    engine_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_zero_operand();
    test_random();
    test_spurious_done();
    test_reset_mid_job();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
